// File: rtl/mem_pkg.sv
// mem_pkg: shared types and default widths for the two-port RAM arbiter.
package mem_pkg;

    localparam int unsigned AW_DEFAULT = 8;
    localparam int unsigned DW_DEFAULT = 8;

    // Sequencer states: arbitrate, hold the access, wait for MFC to drop.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RELEASE = 2'd2
    } state_e;

    // Which requester currently owns (or last owned) the RAM port.
    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch/data requester handshakes plus the shared RAM port.
// The slave modport is the arbiter's view; master is the requesters + RAM side.
interface mem_arbiter_if #(
    parameter int unsigned AW = mem_pkg::AW_DEFAULT,
    parameter int unsigned DW = mem_pkg::DW_DEFAULT
);

    // Fetch requester (read only)
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_ack;
    logic [DW-1:0] f_rdata;

    // Data requester (load/store)
    logic          d_req;
    logic          d_rnw;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;

    // RAM port
    logic [AW-1:0] MAR;
    logic          enable;
    logic          rnw;
    logic [DW-1:0] bus;
    logic [DW-1:0] MBR;
    logic          MFC;

    logic          err;

    modport slave (
        input  f_req, f_addr, d_req, d_rnw, d_addr, d_wdata, MBR, MFC,
        output f_ack, f_rdata, d_ack, d_rdata, MAR, enable, rnw, bus, err
    );

    modport master (
        output f_req, f_addr, d_req, d_rnw, d_addr, d_wdata, MBR, MFC,
        input  f_ack, f_rdata, d_ack, d_rdata, MAR, enable, rnw, bus, err
    );

endinterface

// File: rtl/mem_sync2.sv
// mem_sync2: two-flop synchronizer bringing the RAM's MFC into the CLK domain.
module mem_sync2 (
    input  logic CLK,
    input  logic RST,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage shift; both stages clear on reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter/sequencer sharing one RAM port between the
// instruction-fetch and data requesters.
// Optional feature macro: MEM_ARB_TIMEOUT_EN (abort an ACCESS after TIMEOUT
// cycles without MFC, signalled by err alongside the owner's ack).
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned AW      = AW_DEFAULT,
    parameter int unsigned DW      = DW_DEFAULT,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic         CLK,
    input  logic         RST,
    mem_arbiter_if.slave arb_if
);

    logic mfc_s;

    state_e        state_q,   state_d;
    owner_e        owner_q,   owner_d;
    owner_e        last_q,    last_d;
    owner_e        winner;
    logic [AW-1:0] mar_q,     mar_d;
    logic          rnw_q,     rnw_d;
    logic [DW-1:0] bus_q,     bus_d;
    logic          enable_q,  enable_d;
    logic          f_ack_q,   f_ack_d;
    logic          d_ack_q,   d_ack_d;
    logic [DW-1:0] f_rdata_q, f_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          done;

`ifdef MEM_ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    mem_sync2 u_sync (
        .CLK (CLK),
        .RST (RST),
        .d_i (arb_if.MFC),
        .q_o (mfc_s)
    );

    // Round-robin pick: on a tie, the requester not granted last time wins.
    always_comb begin
        if (arb_if.f_req && arb_if.d_req) begin
            winner = (last_q == OWN_DATA) ? OWN_FETCH : OWN_DATA;
        end else if (arb_if.f_req) begin
            winner = OWN_FETCH;
        end else begin
            winner = OWN_DATA;
        end
    end

    // Next-state and registered-output logic for the IDLE/ACCESS/RELEASE sequencer.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        mar_d     = mar_q;
        rnw_d     = rnw_q;
        bus_d     = bus_q;
        enable_d  = enable_q;
        f_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        f_rdata_d = f_rdata_q;
        d_rdata_d = d_rdata_q;
        done      = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                // A high mfc_s means the RAM has not yet released; grant nothing.
                if (!mfc_s && (arb_if.f_req || arb_if.d_req)) begin
                    owner_d  = winner;
                    enable_d = 1'b1;
                    state_d  = ACCESS;
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                    if (winner == OWN_FETCH) begin
                        mar_d = arb_if.f_addr;
                        rnw_d = 1'b1;
                        bus_d = '0;
                    end else begin
                        mar_d = arb_if.d_addr;
                        rnw_d = arb_if.d_rnw;
                        bus_d = arb_if.d_rnw ? '0 : arb_if.d_wdata;
                    end
                end
            end
            ACCESS: begin
`ifdef MEM_ARB_TIMEOUT_EN
                cnt_d = cnt_q + 8'd1;
`endif
                if (mfc_s) begin
                    done = 1'b1;
                    if (rnw_q) begin
                        if (owner_q == OWN_FETCH) begin
                            f_rdata_d = arb_if.MBR;
                        end else begin
                            d_rdata_d = arb_if.MBR;
                        end
                    end
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    // Abort: ack the owner with err, rdata left untouched.
                    done  = 1'b1;
                    err_d = 1'b1;
                end
`endif
                if (done) begin
                    f_ack_d  = (owner_q == OWN_FETCH);
                    d_ack_d  = (owner_q == OWN_DATA);
                    enable_d = 1'b0;
                    last_d   = owner_q;
                    state_d  = RELEASE;
                end
            end
            RELEASE: begin
                // Keeps MFC low at the RAM before the next enable rising edge.
                if (!mfc_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            owner_q   <= OWN_FETCH;
            last_q    <= OWN_DATA;
            mar_q     <= '0;
            rnw_q     <= 1'b1;
            bus_q     <= '0;
            enable_q  <= 1'b0;
            f_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            mar_q     <= mar_d;
            rnw_q     <= rnw_d;
            bus_q     <= bus_d;
            enable_q  <= enable_d;
            f_ack_q   <= f_ack_d;
            d_ack_q   <= d_ack_d;
            f_rdata_q <= f_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // Access cycle counter and abort flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign arb_if.err = err_q;
`else
    assign arb_if.err = 1'b0;
`endif

    assign arb_if.MAR     = mar_q;
    assign arb_if.rnw     = rnw_q;
    assign arb_if.bus     = bus_q;
    assign arb_if.enable  = enable_q;
    assign arb_if.f_ack   = f_ack_q;
    assign arb_if.d_ack   = d_ack_q;
    assign arb_if.f_rdata = f_rdata_q;
    assign arb_if.d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table, corner-case sequences and a randomized
// run checked against a transaction-level model of the arbiter and RAM.
module tb_mem_arbiter;

    logic clk;
    logic rst;

    mem_arbiter_if ifc ();

    mem_arbiter #(
        .AW      (8),
        .DW      (8),
        .TIMEOUT (16)
    ) dut (
        .CLK    (clk),
        .RST    (rst),
        .arb_if (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] ram       [256];
    logic [7:0] model_ram [256];
    int         ram_lat   = 0;
    bit         mfc_block = 1'b0;

    typedef struct {
        logic       is_f;
        logic       rnw;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         lat;
        logic       exp_rnw;
        logic [7:0] exp_bus;
        logic [7:0] exp_rdata;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] init_val(input int a);
        return (a == 8) ? 8'h01 : (8'(a) ^ 8'h5A);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // RAM: raises MFC ram_lat falling edges after enable, drops it once enable is low.
    initial begin
        int lat_cnt;
        lat_cnt = 0;
        for (int i = 0; i < 256; i++) ram[i] = init_val(i);
        ifc.MFC = 1'b0;
        ifc.MBR = 8'h00;
        forever begin
            @(negedge clk);
            if (ifc.enable !== 1'b1) begin
                ifc.MFC = 1'b0;
                lat_cnt = 0;
            end else if (!ifc.MFC && !mfc_block) begin
                if (lat_cnt >= ram_lat) begin
                    if (ifc.rnw) ifc.MBR = ram[ifc.MAR];
                    else ram[ifc.MAR] = ifc.bus;
                    ifc.MFC = 1'b1;
                end else begin
                    lat_cnt++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_vec(input vec_t v, input int idx);
        bit seen;
        bit wrong;
        int t;
        ram_lat = v.lat;
        if (v.is_f) begin
            ifc.f_req  = 1'b1;
            ifc.f_addr = v.addr;
        end else begin
            ifc.d_req   = 1'b1;
            ifc.d_rnw   = v.rnw;
            ifc.d_addr  = v.addr;
            ifc.d_wdata = v.wdata;
        end
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            seen = ifc.enable;
        end
        check($sformatf("v%0d grant", idx), 32'(seen), 1);
        if (!seen) begin
            ifc.f_req = 1'b0;
            ifc.d_req = 1'b0;
            return;
        end
        check($sformatf("v%0d MAR", idx), 32'(ifc.MAR), 32'(v.addr));
        check($sformatf("v%0d rnw", idx), 32'(ifc.rnw), 32'(v.exp_rnw));
        check($sformatf("v%0d bus", idx), 32'(ifc.bus), 32'(v.exp_bus));
        seen  = 1'b0;
        wrong = 1'b0;
        t     = 0;
        while (!seen && t < 40) begin
            tick();
            t++;
            seen  = v.is_f ? ifc.f_ack : ifc.d_ack;
            wrong = wrong | (v.is_f ? ifc.d_ack : ifc.f_ack);
        end
        ifc.f_req = 1'b0;
        ifc.d_req = 1'b0;
        check($sformatf("v%0d ack", idx), 32'(seen), 1);
        check($sformatf("v%0d ack latency", idx), t, 3 + v.lat);
        check($sformatf("v%0d enable low at ack", idx), 32'(ifc.enable), 0);
        check($sformatf("v%0d no foreign ack", idx), 32'(wrong), 0);
        if (v.exp_rnw) begin
            check($sformatf("v%0d rdata", idx),
                  32'(v.is_f ? ifc.f_rdata : ifc.d_rdata), 32'(v.exp_rdata));
        end else begin
            model_ram[v.addr] = v.wdata;
        end
    endtask

    initial begin
        vec_t vecs [8];
        vec_t pre;
        bit   seen;
        int   t;
        int   n_ack;
        int   dbl;
        int   consec;
        int   en_rises;
        bit   prev_ack;
        bit   prev_en;
        int   order [4];

        for (int i = 0; i < 256; i++) model_ram[i] = init_val(i);
        rst         = 1'b1;
        ifc.f_req   = 1'b0;
        ifc.f_addr  = 8'h00;
        ifc.d_req   = 1'b0;
        ifc.d_rnw   = 1'b1;
        ifc.d_addr  = 8'h00;
        ifc.d_wdata = 8'h00;

        // Reset state
        repeat (3) tick();
        check("reset enable",  32'(ifc.enable),  0);
        check("reset rnw",     32'(ifc.rnw),     1);
        check("reset MAR",     32'(ifc.MAR),     0);
        check("reset bus",     32'(ifc.bus),     0);
        check("reset f_ack",   32'(ifc.f_ack),   0);
        check("reset d_ack",   32'(ifc.d_ack),   0);
        check("reset f_rdata", 32'(ifc.f_rdata), 0);
        check("reset d_rdata", 32'(ifc.d_rdata), 0);
        check("reset err",     32'(ifc.err),     0);
        rst = 1'b0;
        tick();

        // Directed single-requester vectors
        vecs[0] = '{is_f: 1'b1, rnw: 1'b1, addr: 8'h08, wdata: 8'h00, lat: 0,
                    exp_rnw: 1'b1, exp_bus: 8'h00, exp_rdata: 8'h01};
        vecs[1] = '{is_f: 1'b0, rnw: 1'b0, addr: 8'h20, wdata: 8'hA5, lat: 1,
                    exp_rnw: 1'b0, exp_bus: 8'hA5, exp_rdata: 8'h00};
        vecs[2] = '{is_f: 1'b0, rnw: 1'b1, addr: 8'h20, wdata: 8'hFF, lat: 0,
                    exp_rnw: 1'b1, exp_bus: 8'h00, exp_rdata: 8'hA5};
        vecs[3] = '{is_f: 1'b1, rnw: 1'b1, addr: 8'h20, wdata: 8'h00, lat: 2,
                    exp_rnw: 1'b1, exp_bus: 8'h00, exp_rdata: 8'hA5};
        vecs[4] = '{is_f: 1'b0, rnw: 1'b0, addr: 8'hFF, wdata: 8'h5A, lat: 0,
                    exp_rnw: 1'b0, exp_bus: 8'h5A, exp_rdata: 8'h00};
        vecs[5] = '{is_f: 1'b0, rnw: 1'b1, addr: 8'hFF, wdata: 8'h00, lat: 3,
                    exp_rnw: 1'b1, exp_bus: 8'h00, exp_rdata: 8'h5A};
        vecs[6] = '{is_f: 1'b0, rnw: 1'b1, addr: 8'h03, wdata: 8'h00, lat: 0,
                    exp_rnw: 1'b1, exp_bus: 8'h00, exp_rdata: 8'h59};
        vecs[7] = '{is_f: 1'b1, rnw: 1'b1, addr: 8'h00, wdata: 8'h00, lat: 1,
                    exp_rnw: 1'b1, exp_bus: 8'h00, exp_rdata: 8'h5A};
        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Contention straight after reset: fetch, data, fetch, data
        repeat (8) tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        ram_lat     = 0;
        ifc.f_req   = 1'b1;
        ifc.f_addr  = 8'h01;
        ifc.d_req   = 1'b1;
        ifc.d_rnw   = 1'b1;
        ifc.d_addr  = 8'h02;
        n_ack = 0; dbl = 0; consec = 0; en_rises = 0; prev_ack = 1'b0; prev_en = 1'b0;
        for (int c = 0; c < 120 && n_ack < 4; c++) begin
            tick();
            if (ifc.enable && !prev_en) en_rises++;
            prev_en = ifc.enable;
            if (ifc.f_ack && ifc.d_ack) dbl++;
            if ((ifc.f_ack || ifc.d_ack) && prev_ack) consec++;
            prev_ack = ifc.f_ack | ifc.d_ack;
            if (ifc.f_ack) begin
                order[n_ack] = 0;
                n_ack++;
            end else if (ifc.d_ack) begin
                order[n_ack] = 1;
                n_ack++;
            end
        end
        ifc.f_req = 1'b0;
        ifc.d_req = 1'b0;
        check("contention ack count", n_ack, 4);
        if (n_ack == 4) begin
            for (int i = 0; i < 4; i++) check($sformatf("contention order %0d", i), order[i], i % 2);
        end
        check("contention one grant per ack", en_rises, n_ack);
        check("contention double ack", dbl, 0);
        check("contention ack longer than 1 cycle", consec, 0);
        check("contention f_rdata", 32'(ifc.f_rdata), 32'h5B);
        check("contention d_rdata", 32'(ifc.d_rdata), 32'h58);

        // Reset one cycle into an access
        repeat (8) tick();
        ram_lat    = 6;
        ifc.f_req  = 1'b1;
        ifc.f_addr = 8'h08;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            seen = ifc.enable;
        end
        check("rstmid grant", 32'(seen), 1);
        rst = 1'b1;
        tick();
        check("rstmid enable", 32'(ifc.enable), 0);
        check("rstmid no ack", 32'({ifc.f_ack, ifc.d_ack}), 0);
        check("rstmid f_rdata cleared", 32'(ifc.f_rdata), 0);
        rst     = 1'b0;
        ram_lat = 0;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            seen = ifc.enable;
        end
        check("rstmid regrant", 32'(seen), 1);
        check("rstmid regrant MAR", 32'(ifc.MAR), 32'h08);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = ifc.f_ack;
        end
        ifc.f_req = 1'b0;
        check("rstmid ack", 32'(seen), 1);
        check("rstmid f_rdata", 32'(ifc.f_rdata), 32'h01);

        // MFC held low during a data read
        pre = '{is_f: 1'b0, rnw: 1'b1, addr: 8'h03, wdata: 8'h00, lat: 0,
                exp_rnw: 1'b1, exp_bus: 8'h00, exp_rdata: 8'h59};
        run_vec(pre, 8);
        repeat (6) tick();
        mfc_block  = 1'b1;
        ifc.d_req  = 1'b1;
        ifc.d_rnw  = 1'b1;
        ifc.d_addr = 8'h20;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            seen = ifc.enable;
        end
        check("stuck grant", 32'(seen), 1);
`ifdef MEM_ARB_TIMEOUT_EN
        seen = 1'b0;
        t    = 0;
        while (!seen && t < 40) begin
            tick();
            t++;
            seen = ifc.d_ack;
        end
        check("timeout ack", 32'(seen), 1);
        check("timeout latency", t, 16);
        check("timeout err", 32'(ifc.err), 1);
        check("timeout d_rdata kept", 32'(ifc.d_rdata), 32'h59);
        check("timeout enable low", 32'(ifc.enable), 0);
        ifc.d_req = 1'b0;
        mfc_block = 1'b0;
        tick();
        check("timeout err one cycle", 32'(ifc.err), 0);
        check("timeout ack one cycle", 32'(ifc.d_ack), 0);
`else
        n_ack = 0;
        t     = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n_ack += int'(ifc.f_ack | ifc.d_ack);
            t     += int'(ifc.err);
        end
        check("stuck no ack", n_ack, 0);
        check("stuck no err", t, 0);
        check("stuck enable held", 32'(ifc.enable), 1);
        mfc_block = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = ifc.d_ack;
        end
        ifc.d_req = 1'b0;
        check("stuck late ack", 32'(seen), 1);
        check("stuck d_rdata", 32'(ifc.d_rdata), 32'hA5);
        check("stuck err", 32'(ifc.err), 0);
`endif

        // Randomized traffic against a transaction-level model
        repeat (8) tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        begin
            bit         last_d;
            bit         busy;
            bit         cur_d;
            bit         cur_rnw;
            bit         exp_d;
            logic [7:0] cur_addr;
            logic [7:0] cur_wdata;
            int         t_grant;
            bit         en_prev;
            int         n_acks;
            last_d = 1'b1; busy = 1'b0; en_prev = 1'b0; n_acks = 0; t_grant = 0;
            cur_d = 1'b0; cur_rnw = 1'b1; cur_addr = 8'h00; cur_wdata = 8'h00;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                tick();
                if (ifc.enable && !en_prev) begin
                    check("rnd grant needs req", 32'(ifc.f_req | ifc.d_req), 1);
                    exp_d     = (ifc.f_req && ifc.d_req) ? !last_d : ifc.d_req;
                    cur_d     = exp_d;
                    cur_addr  = exp_d ? ifc.d_addr : ifc.f_addr;
                    cur_rnw   = exp_d ? ifc.d_rnw : 1'b1;
                    cur_wdata = ifc.d_wdata;
                    check("rnd grant MAR", 32'(ifc.MAR), 32'(cur_addr));
                    check("rnd grant rnw", 32'(ifc.rnw), 32'(cur_rnw));
                    check("rnd grant bus", 32'(ifc.bus), cur_rnw ? 32'h0 : 32'(cur_wdata));
                    busy    = 1'b1;
                    t_grant = cyc;
                end
                if (ifc.f_ack || ifc.d_ack) begin
                    check("rnd ack owner", 32'({ifc.f_ack, ifc.d_ack}), cur_d ? 32'h1 : 32'h2);
                    check("rnd ack while busy", 32'(busy), 1);
                    check("rnd ack latency", 32'((cyc - t_grant) >= 3), 1);
                    check("rnd enable low at ack", 32'(ifc.enable), 0);
                    if (cur_rnw) begin
                        check("rnd rdata", 32'(cur_d ? ifc.d_rdata : ifc.f_rdata),
                              32'(model_ram[cur_addr]));
                    end else begin
                        model_ram[cur_addr] = cur_wdata;
                    end
                    last_d = cur_d;
                    busy   = 1'b0;
                    n_acks++;
                    if (ifc.f_ack) ifc.f_req = 1'b0;
                    if (ifc.d_ack) ifc.d_req = 1'b0;
                end
                if (busy && (cyc - t_grant) > 40) begin
                    check("rnd ack timely", cyc - t_grant, 40);
                    busy = 1'b0;
                end
                en_prev = ifc.enable;
                if (!ifc.f_req && $urandom_range(0, 2) == 0) begin
                    ifc.f_req  = 1'b1;
                    ifc.f_addr = 8'($urandom_range(0, 15));
                end
                if (!ifc.d_req && $urandom_range(0, 2) == 0) begin
                    ifc.d_req   = 1'b1;
                    ifc.d_rnw   = 1'($urandom_range(0, 1));
                    ifc.d_addr  = 8'($urandom_range(0, 15));
                    ifc.d_wdata = 8'($urandom);
                end
                if (!ifc.enable) ram_lat = $urandom_range(0, 3);
            end
            check("rnd enough traffic", 32'(n_acks > 100), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the 256x8 RAM. It shares the RAM's single MAR/enable/rnw/bus port between the instruction-fetch requester and the data (load/store) requester. It drives the RAM's enable/MFC handshake and returns read data and completion to the winning requester. It sits between the control unit and the RAM, replacing direct MAR/enable drive from either requester.

## Interface
Parameters:
- AW, 8, address width (MAR width)
- DW, 8, data width
- TIMEOUT, 16, max cycles spent in ACCESS before abort (only used with MEM_ARB_TIMEOUT_EN)

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- f_req  in  1  fetch request (read only); level, held until f_ack
- f_addr  in  AW  fetch address; stable while f_req high
- f_ack  out  1  one-cycle completion pulse to fetch
- f_rdata  out  DW  fetch read data; valid from f_ack cycle until next fetch ack
- d_req  in  1  data request; level, held until d_ack
- d_rnw  in  1  1 = read, 0 = write
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_ack  out  1  one-cycle completion pulse to data port
- d_rdata  out  DW  data read result; valid from d_ack until next data read ack
- MAR  out  AW  RAM address
- enable  out  1  RAM access strobe
- rnw  out  1  RAM direction
- bus  out  DW  RAM write data
- MBR  in  DW  RAM read data
- MFC  in  1  RAM function complete; asynchronous to CLK
- err  out  1  one-cycle pulse coincident with an aborted ack

## Operation
- MFC passes through a 2-flop synchronizer (mfc_s); the FSM uses only mfc_s.
- States: IDLE, ACCESS, RELEASE.
- IDLE: if mfc_s==0 and any req, arbitrate. Register MAR, rnw, bus from the winner, set enable=1, store owner, go to ACCESS. If mfc_s==1, stall and grant nothing.
- Arbitration is round-robin. A 1-bit last_grant picks the other requester on a tie. A sole requester always wins. Reset value of last_grant is data, so fetch wins the first tie. Fetch always uses rnw=1.
- ACCESS: hold MAR/rnw/bus/enable. On mfc_s==1:
  - if read, capture MBR into the owner's rdata
  - pulse the owner's ack
  - enable←0, update last_grant, go to RELEASE
- RELEASE: wait for mfc_s==0, then go to IDLE. This guarantees the RAM's MFC low before the next enable rising edge.
- A requester holding req high through its ack cycle is treated as a new request in the next IDLE.
- Outputs change only in the state transitions above. bus equals d_wdata latched at grant; it is 0 for reads.
- Reset values: state IDLE, enable 0, rnw 1, MAR 0, bus 0, f_ack 0, d_ack 0, f_rdata 0, d_rdata 0, err 0, synchronizer flops 0.

## Timing
- Grant: enable rises at the first CLK edge after req is seen in IDLE with mfc_s==0.
- Ack: no earlier than 3 edges after enable rises (RAM MFC, then 2 synchronizer stages). The acked requester has exactly 1 ack cycle.
- Back-to-back minimum: ack → RELEASE → ≥2 edges for mfc_s to fall → IDLE → grant. There is never overlap between two enable pulses.
- Reset mid-operation: at the next edge, enable←0 and state←IDLE with no ack issued. A new grant is then blocked until mfc_s==0.
- Simultaneous f_req and d_req in IDLE resolve per last_grant in the same cycle. The loser waits, with no ack, until the next IDLE.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - an 8-bit counter clears on entering ACCESS and increments each cycle in ACCESS
  - at count==TIMEOUT-1 without mfc_s: enable←0, pulse the owner's ack together with err=1, leave the owner's rdata unchanged, go to RELEASE
- MEM_ARB_TIMEOUT_EN undefined:
  - no counter; ACCESS waits indefinitely
  - err is tied 0 and TIMEOUT is ignored

## Structure
- Package mem_pkg holds:
  - the state enum (IDLE, ACCESS, RELEASE)
  - the owner enum (OWN_FETCH, OWN_DATA)
  - AW/DW default constants
- Sub-module mem_sync2: 2-flop synchronizer for MFC, reset to 0 by RST. Everything else stays in mem_arbiter.

## Test plan
- Fetch read: RAM[8]=0x01, f_req with f_addr=8 → enable high with MAR=8, rnw=1; then f_ack pulse with f_rdata=0x01; enable low before f_ack+1.
- Data write then read: d_rnw=0, d_addr=0x20, d_wdata=0xA5 → d_ack; then d_rnw=1, d_addr=0x20 → d_rdata=0xA5.
- Contention: f_req and d_req both raised at the same edge after reset, both held high → order fetch, data, fetch, data; exactly one ack per access; enable pulses never overlap.
- Reset mid-ACCESS: assert RST 1 cycle after enable rises → enable=0 and no ack next edge. Hold f_req → regrant only after mfc_s reads 0.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT=16): tie MFC low, issue d_req → d_ack and err pulse together 16 cycles after enable rises; d_rdata unchanged.
